// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Adds a start/busy/done handshake and a saturating overflow flag.
module seq_bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    shift_reg, shift_shifted;
    logic [4*DIGITS-1:0] digits, corrected, digits_shifted;
    logic [CW-1:0]       count;
    logic                track, track_next, carry_out, last_iter;

    // One double-dabble step: correct each digit, then shift the operand MSB into digit 0.
    always_comb begin
        corrected = digits;
        for (int k = 0; k < DIGITS; k++) begin
            if (digits[4*k +: 4] >= 4'd5) begin
                corrected[4*k +: 4] = digits[4*k +: 4] + 4'd3;
            end
        end
        {carry_out, digits_shifted} = {corrected, shift_reg[WIDTH-1]};
        shift_shifted = shift_reg << 1;
        track_next    = track | carry_out;
        last_iter     = (count == CW'(1));

        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CONV;
            CONV: begin
                busy = 1'b1;
                if (last_iter) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are registered on the last iteration and held until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            digits    <= '0;
            count     <= '0;
            track     <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        digits    <= '0;
                        track     <= 1'b0;
                        count     <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    shift_reg <= shift_shifted;
                    digits    <= digits_shifted;
                    track     <= track_next;
                    count     <= count - CW'(1);
                    if (last_iter) begin
                        bcd      <= track_next ? {DIGITS{4'h9}} : digits_shifted;
                        overflow <= track_next;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: three configurations checked every cycle against a decimal
// arithmetic model, plus directed scenarios with hand-computed results.
module tb_seq_bin_to_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start4 = 1'b0, start5 = 1'b0, start8 = 1'b0;
    logic [15:0] bin4 = '0, bin5 = '0;
    logic [7:0]  bin8 = '0;

    logic        busy4, done4, ovf4, busy5, done5, ovf5, busy8, done8, ovf8;
    logic [15:0] bcd4;
    logic [19:0] bcd5;
    logic [7:0]  bcd8;

    logic        act_busy[3], act_done[3], act_ovf[3];
    logic [19:0] act_bcd[3];

    int          compared = 0;
    int          mismatched = 0;
    logic        checking = 1'b0;

    int          rem[3] = '{0, 0, 0};
    logic        e_done[3] = '{0, 0, 0};
    logic        e_ovf[3] = '{0, 0, 0};
    logic [19:0] e_bcd[3] = '{0, 0, 0};
    logic        p_ovf[3] = '{0, 0, 0};
    logic [19:0] p_bcd[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    seq_bin_to_bcd #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4));

    seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .bin(bin5),
        .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5));

    seq_bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8));

    assign act_busy[0] = busy4;  assign act_done[0] = done4;  assign act_ovf[0] = ovf4;
    assign act_busy[1] = busy5;  assign act_done[1] = done5;  assign act_ovf[1] = ovf5;
    assign act_busy[2] = busy8;  assign act_done[2] = done8;  assign act_ovf[2] = ovf8;
    assign act_bcd[0] = {4'h0, bcd4};
    assign act_bcd[1] = bcd5;
    assign act_bcd[2] = {12'h0, bcd8};

    // Decimal conversion by division; values that do not fit saturate to all nines.
    function automatic logic [20:0] to_bcd(input int v, input int nd);
        logic [19:0] r;
        int limit;
        int t;
        r = '0;
        limit = 1;
        for (int k = 0; k < nd; k++) limit = limit * 10;
        if (v >= limit) begin
            for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'd9;
            return {1'b1, r};
        end
        t = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic st, input int b, input int w, input int nd);
        logic [20:0] r;
        if (reset) begin
            rem[i] = 0;  e_done[i] = 0;  e_bcd[i] = '0;  e_ovf[i] = 0;
        end else begin
            e_done[i] = 0;
            if (rem[i] == 0) begin
                if (st) begin
                    rem[i] = w;
                    r = to_bcd(b, nd);
                    p_ovf[i] = r[20];
                    p_bcd[i] = r[19:0];
                end
            end else begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) begin
                    e_done[i] = 1;
                    e_bcd[i] = p_bcd[i];
                    e_ovf[i] = p_ovf[i];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, start4, int'(bin4), 16, 4);
        model_step(1, start5, int'(bin5), 16, 5);
        model_step(2, start8, int'(bin8), 8, 2);
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy%0d", i), 32'(act_busy[i]), 32'(rem[i] > 0));
                check($sformatf("done%0d", i), 32'(act_done[i]), 32'(e_done[i]));
                check($sformatf("bcd%0d", i), 32'(act_bcd[i]), 32'(e_bcd[i]));
                check($sformatf("ovf%0d", i), 32'(act_ovf[i]), 32'(e_ovf[i]));
            end
        end
    end

    task automatic set_start(input int i, input logic s, input int b);
        case (i)
            0: begin start4 = s; bin4 = 16'(b); end
            1: begin start5 = s; bin5 = 16'(b); end
            default: begin start8 = s; bin8 = 8'(b); end
        endcase
    endtask

    task automatic apply_stimulus(input int i, input int b);
        set_start(i, 1'b1, b);
        @(posedge clk);
        #1;
        set_start(i, 1'b0, int'($urandom));
    endtask

    task automatic wait_done(input int i, input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (act_done[i]) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int i, input int b, input logic [19:0] exp_bcd,
                                input logic exp_ovf, input int w);
        int lat;
        apply_stimulus(i, b);
        wait_done(i, w + 8, lat);
        check($sformatf("latency%0d_%0d", i, b), 32'(lat), 32'(w + 1));
        check($sformatf("result%0d_%0d", i, b), 32'(act_bcd[i]), 32'(exp_bcd));
        check($sformatf("overflow%0d_%0d", i, b), 32'(act_ovf[i]), 32'(exp_ovf));
    endtask

    initial begin
        int lat;
        int ndone;

        check("model_20", 32'(to_bcd(20, 4)), 32'({1'b0, 20'h00020}));
        check("model_10000", 32'(to_bcd(10000, 4)), 32'({1'b1, 20'h09999}));
        check("model_65535", 32'(to_bcd(65535, 5)), 32'({1'b0, 20'h65535}));
        check("model_255", 32'(to_bcd(255, 2)), 32'({1'b1, 20'h00099}));

        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy%0d", i), 32'(act_busy[i]), 32'(0));
            check($sformatf("reset_bcd%0d", i), 32'(act_bcd[i]), 32'(0));
        end

        check_output(0, 20, 20'h00020, 1'b0, 16);
        check_output(0, 9999, 20'h09999, 1'b0, 16);
        check_output(0, 10000, 20'h09999, 1'b1, 16);
        check_output(0, 0, 20'h00000, 1'b0, 16);
        check_output(1, 65535, 20'h65535, 1'b0, 16);
        check_output(1, 1234, 20'h01234, 1'b0, 16);

        // Starts while busy are ignored; a start in the done cycle is accepted.
        set_start(0, 1'b1, 4321);
        @(posedge clk);
        #1;
        set_start(0, 1'b0, 1111);
        ndone = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (act_done[0]) ndone++;
            if (c == 17) begin
                check("bb_done_cycle", 32'(act_done[0]), 32'(1));
                check("bb_first", 32'(act_bcd[0]), 32'(20'h04321));
                check("bb_one_done", 32'(ndone), 32'(1));
                set_start(0, 1'b1, 8765);
            end else begin
                set_start(0, (c == 2 || c == 9), 1111);
            end
        end
        @(posedge clk);
        #1;
        set_start(0, 1'b0, 0);
        wait_done(0, 25, lat);
        check("bb_latency", 32'(lat), 32'(17));
        check("bb_second", 32'(act_bcd[0]), 32'(20'h08765));

        apply_stimulus(0, 5555);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(act_busy[0]), 32'(0));
        check("abort_bcd", 32'(act_bcd[0]), 32'(0));
        check("abort_ovf", 32'(act_ovf[0]), 32'(0));
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (act_done[0]) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'(0));
        @(posedge clk);
        #1;
        check_output(0, 1234, 20'h01234, 1'b0, 16);

        check_output(2, 255, 20'h00099, 1'b1, 8);
        check_output(2, 99, 20'h00099, 1'b0, 8);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
